// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller.
//   ramp_state_e : controller states (idle, load, ramp, done)
//   DefWidthW    : default width of the duty setting
//   DefClkW      : default width of the PWM clock select
//   MaxWidthW    : widest duty setting the step helper supports
//   ramp_next()  : next duty level, saturating at the target
package pwm_pkg;

  localparam int unsigned DefWidthW = 4;
  localparam int unsigned DefClkW   = 4;
  localparam int unsigned DefDwellW = 16;
  localparam int unsigned MaxWidthW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRamp,
    StDone
  } ramp_state_e;

  typedef logic [MaxWidthW-1:0] level_t;

  // Move cur one step towards tgt without passing it. A zero step counts as one.
  // The extra bit keeps the up-sum from wrapping.
  function automatic level_t ramp_next(level_t cur, level_t tgt, level_t step);
    logic [MaxWidthW:0] cur_x;
    logic [MaxWidthW:0] tgt_x;
    logic [MaxWidthW:0] stp_x;
    logic [MaxWidthW:0] sum_x;
    logic [MaxWidthW:0] gap_x;
    level_t             res;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    stp_x = (step == '0) ? (MaxWidthW + 1)'(1) : {1'b0, step};
    sum_x = cur_x + stp_x;
    gap_x = cur_x - tgt_x;
    if (tgt_x > cur_x) begin
      res = (sum_x > tgt_x) ? tgt : sum_x[MaxWidthW-1:0];
    end else if (tgt_x < cur_x) begin
      // Down: clamp when the step is larger than the remaining distance.
      res = (stp_x > gap_x) ? tgt : level_t'(cur_x - stp_x);
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_dwell_timer.sv
// Loadable down-counter that times how long each duty level is held.
//   clk      : clock, rising edge
//   s_rst    : synchronous active-high reset, clears the count
//   load     : load load_val (takes priority over counting)
//   load_val : reload value
//   en       : count down by one while non-zero
//   zero     : count is zero
module pwm_dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               s_rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for a pwm core: on start, walks sel_width from its current
// value to cfg_target in cfg_step increments, holding each level cfg_dwell+1
// cycles, then pulses done.
//   clk        : clock, rising edge
//   s_rst      : synchronous active-high reset
//   start      : ramp request, honoured only when idle
//   abort      : cancel an active ramp, wins over start
//   cfg_target : final duty setting
//   cfg_step   : per-step change (0 behaves as 1)
//   cfg_dwell  : extra cycles held at each level
//   cfg_clk    : pwm clock select for this ramp
//   busy       : ramp in progress (load or ramp state)
//   done       : one-cycle pulse on normal completion
//   sel_width  : pwm duty select
//   sel_clk    : pwm clock select
//   pwm_s_rst  : pwm divider reset, pulsed while loading a new ramp
// WIDTH_W must not exceed MaxWidthW.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH_W = DefWidthW,
  parameter int unsigned CLK_W   = DefClkW,
  parameter int unsigned DWELL_W = DefDwellW
) (
  input  logic               clk,
  input  logic               s_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH_W-1:0] cfg_target,
  input  logic [WIDTH_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [CLK_W-1:0]   cfg_clk,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_W-1:0] sel_width,
  output logic [CLK_W-1:0]   sel_clk,
  output logic               pwm_s_rst
);

  ramp_state_e state_q, state_d;

  logic [WIDTH_W-1:0] width_q, width_d;
  logic [CLK_W-1:0]   clk_sel_q, clk_sel_d;
  logic [WIDTH_W-1:0] target_q, target_d;
  logic [WIDTH_W-1:0] step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               prst_q, prst_d;

  logic               timer_load;
  logic               timer_en;
  logic               dwell_zero;

  level_t             next_level;
  logic [WIDTH_W-1:0] width_next;
  logic               at_target;
  logic               unused_level_bits;

  assign next_level = ramp_next(level_t'(width_q), level_t'(target_q), level_t'(step_q));
  assign width_next = next_level[WIDTH_W-1:0];
  assign at_target  = (width_q == target_q);
  // Saturation keeps the result within WIDTH_W bits; the upper bits are always zero.
  assign unused_level_bits = ^(next_level >> WIDTH_W);

  pwm_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .s_rst    (s_rst),
    .load     (timer_load),
    .load_val (dwell_q),
    .en       (timer_en),
    .zero     (dwell_zero)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q   <= StIdle;
      width_q   <= '0;
      clk_sel_q <= '0;
      target_q  <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prst_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      clk_sel_q <= clk_sel_d;
      target_q  <= target_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      prst_q    <= prst_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = abort ? StIdle : StRamp;
      end
      StRamp: begin
        if (abort) begin
          state_d = StIdle;
        end else if (dwell_zero && at_target) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output / datapath next values. Flags are derived from the state being
  // entered so that they are registered alongside it.
  always_comb begin
    width_d    = width_q;
    clk_sel_d  = clk_sel_q;
    target_d   = target_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    busy_d     = (state_d == StLoad) || (state_d == StRamp);
    done_d     = (state_d == StDone);
    prst_d     = (state_d == StLoad);
    timer_load = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (state_d == StLoad) begin
          target_d  = cfg_target;
          step_d    = cfg_step;
          dwell_d   = cfg_dwell;
          clk_sel_d = cfg_clk;
        end
      end
      StLoad: begin
        timer_load = (state_d == StRamp);
      end
      StRamp: begin
        timer_en = 1'b1;
        // Level expired and not yet at target: advance and restart the hold.
        if ((state_d == StRamp) && dwell_zero && !at_target) begin
          width_d    = width_next;
          timer_load = 1'b1;
        end
      end
      StDone: begin
      end
      default: begin
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sel_width = width_q;
  assign sel_clk   = clk_sel_q;
  assign pwm_s_rst = prst_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

  localparam int unsigned WIDTH_W = 4;
  localparam int unsigned CLK_W   = 4;
  localparam int unsigned DWELL_W = 16;

  logic               clk = 1'b0;
  logic               s_rst;
  logic               start;
  logic               abort;
  logic [WIDTH_W-1:0] cfg_target;
  logic [WIDTH_W-1:0] cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [CLK_W-1:0]   cfg_clk;
  logic               busy;
  logic               done;
  logic [WIDTH_W-1:0] sel_width;
  logic [CLK_W-1:0]   sel_clk;
  logic               pwm_s_rst;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_w = 0;

  typedef struct {
    int target;
    int step;
    int dwell;
    int clkv;
    int edges;
  } vec_t;

  typedef struct {
    int w;
    int busy;
    int done;
    int prst;
  } exp_t;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .WIDTH_W (WIDTH_W),
    .CLK_W   (CLK_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk        (clk),
    .s_rst      (s_rst),
    .start      (start),
    .abort      (abort),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .cfg_dwell  (cfg_dwell),
    .cfg_clk    (cfg_clk),
    .busy       (busy),
    .done       (done),
    .sel_width  (sel_width),
    .sel_clk    (sel_clk),
    .pwm_s_rst  (pwm_s_rst)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int tgt, input int stp, input int dwl, input int ck);
    cfg_target = WIDTH_W'(tgt);
    cfg_step   = WIDTH_W'(stp);
    cfg_dwell  = DWELL_W'(dwl);
    cfg_clk    = CLK_W'(ck);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int ok);
    edges = 0;
    ok    = 0;
    for (int i = 1; i <= 4000; i++) begin
      tick();
      if (done) begin
        edges = i;
        ok    = 1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    s_rst = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
    cur_w = 0;
  endtask

  // Expected per-cycle trace of a ramp, from the cycle after the start edge
  // through the idle cycle that follows done.
  task automatic build_trace(input int w0, input int tgt, input int stp, input int dwl,
                             output exp_t q[$]);
    int levels[$];
    int w;
    int s;
    q.delete();
    w = w0;
    s = (stp == 0) ? 1 : stp;
    levels.push_back(w);
    while (w != tgt) begin
      if (tgt > w) w = (w + s > tgt) ? tgt : w + s;
      else         w = (w - s < tgt) ? tgt : w - s;
      levels.push_back(w);
    end
    q.push_back('{w0, 1, 0, 1});
    foreach (levels[k]) begin
      for (int d = 0; d <= dwl; d++) q.push_back('{levels[k], 1, 0, 0});
    end
    q.push_back('{tgt, 0, 1, 0});
    q.push_back('{tgt, 0, 0, 0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    exp_t q[$];
    int   edges;
    int   ok;
    int   tgt, stp, dwl, ck;
    int   ew;

    s_rst      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_target = '0;
    cfg_step   = '0;
    cfg_dwell  = '0;
    cfg_clk    = '0;

    // Reset values and pwm_s_rst release.
    apply_reset();
    s_rst = 1'b1;
    tick();
    check("rst_width", sel_width, 0);
    check("rst_clk", sel_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pwm_s_rst", pwm_s_rst, 1);
    s_rst = 1'b0;
    tick();
    check("rst_release_pwm_s_rst", pwm_s_rst, 0);
    check("rst_release_busy", busy, 0);

    // Table: each row ramps from the previous row's target (first from 0).
    // edges = edge index (start edge = 0) after which done is seen.
    tbl[0] = '{4, 1, 2, 3, 16};
    tbl[1] = '{12, 5, 0, 1, 4};
    tbl[2] = '{3, 5, 0, 2, 4};
    tbl[3] = '{5, 0, 1, 4, 7};
    tbl[4] = '{5, 7, 3, 5, 5};
    tbl[5] = '{0, 15, 0, 6, 3};
    tbl[6] = '{15, 15, 1, 9, 5};
    foreach (tbl[i]) begin
      launch(tbl[i].target, tbl[i].step, tbl[i].dwell, tbl[i].clkv);
      check("tbl_load_busy", busy, 1);
      check("tbl_load_pwm_s_rst", pwm_s_rst, 1);
      check("tbl_load_clk", sel_clk, tbl[i].clkv);
      wait_done(edges, ok);
      check("tbl_done_seen", ok, 1);
      check("tbl_done_edge", edges, tbl[i].edges);
      check("tbl_final_width", sel_width, tbl[i].target);
      check("tbl_done_busy", busy, 0);
      tick();
      check("tbl_done_pulse_len", done, 0);
      check("tbl_idle_clk_kept", sel_clk, tbl[i].clkv);
    end

    // Up ramp 0->4, step 1, dwell 2: level changes at edges 4, 7, 10, 13.
    apply_reset();
    tick();
    launch(4, 1, 2, 3);
    check("up_load_clk", sel_clk, 3);
    check("up_load_pwm_s_rst", pwm_s_rst, 1);
    for (int e = 1; e <= 17; e++) begin
      tick();
      ew = (e < 4) ? 0 : (e < 7) ? 1 : (e < 10) ? 2 : (e < 13) ? 3 : 4;
      check("up_width", sel_width, ew);
      check("up_done", done, (e == 16) ? 1 : 0);
      check("up_busy", busy, (e < 16) ? 1 : 0);
      check("up_pwm_s_rst", pwm_s_rst, 0);
    end

    // Abort at width 2 of a 0->8 ramp, with a simultaneous start.
    apply_reset();
    tick();
    launch(8, 1, 1, 2);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (sel_width == 2) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("abort_reach_level", ok, 1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_width", sel_width, 2);
    check("abort_pwm_s_rst", pwm_s_rst, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_idle_busy", busy, 0);
      check("abort_no_done", done, 0);
      check("abort_hold_width", sel_width, 2);
    end
    cur_w = 2;

    // Abort alongside start in idle: no ramp starts.
    cfg_target = 4'd9;
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start      = 1'b0;
    abort      = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_pwm_s_rst", pwm_s_rst, 0);
    tick();
    check("idle_abort_width", sel_width, 2);

    // Abort during done: completion is unaffected.
    launch(5, 1, 0, 0);
    wait_done(edges, ok);
    check("done_abort_seen", ok, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("done_abort_done", done, 0);
    check("done_abort_width", sel_width, 5);
    cur_w = 5;

    // Random ramps against the trace model; cfg and start churn mid-ramp.
    for (int r = 0; r < 30; r++) begin
      tgt = int'($urandom_range(0, 15));
      stp = int'($urandom_range(0, 15));
      dwl = int'($urandom_range(0, 3));
      ck  = int'($urandom_range(0, 15));
      build_trace(cur_w, tgt, stp, dwl, q);
      launch(tgt, stp, dwl, ck);
      for (int i = 0; i < q.size(); i++) begin
        check("rnd_width", sel_width, q[i].w);
        check("rnd_busy", busy, q[i].busy);
        check("rnd_done", done, q[i].done);
        check("rnd_pwm_s_rst", pwm_s_rst, q[i].prst);
        check("rnd_clk", sel_clk, ck);
        cfg_target = WIDTH_W'($urandom);
        cfg_step   = WIDTH_W'($urandom);
        cfg_dwell  = DWELL_W'($urandom_range(0, 7));
        cfg_clk    = CLK_W'($urandom);
        start      = 1'($urandom_range(0, 1));
        if (i < q.size() - 1) tick();
      end
      start = 1'b0;
      cur_w = tgt;
    end

    // Reset in the middle of a ramp.
    launch(15, 3, 0, 7);
    for (int i = 0; i < 5; i++) tick();
    s_rst = 1'b1;
    tick();
    check("midrst_width", sel_width, 0);
    check("midrst_clk", sel_clk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pwm_s_rst", pwm_s_rst, 1);
    s_rst = 1'b0;
    tick();
    check("midrst_release_pwm_s_rst", pwm_s_rst, 0);
    check("midrst_release_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Sequencer that drives the `sel_width` and `sel_clk` configuration inputs of a `pwm` instance. On a start request it ramps the duty setting from its current value to a programmed target. It moves in programmable step sizes, holding each level for a programmable dwell time, and signals completion with a one-cycle pulse. It sits between the register/control logic and the `pwm` core; a top level connects one controller to one `pwm`.

Parameters:
WIDTH_W, 4, width of `sel_width` / `cfg_target` / `cfg_step`
CLK_W, 4, width of `sel_clk` / `cfg_clk`
DWELL_W, 16, width of dwell counter and `cfg_dwell`

Ports:
clk  input  1  single clock; all logic on rising edge
s_rst  input  1  reset, synchronous, active-high
start  input  1  request a ramp; sampled only in IDLE
abort  input  1  cancel an active ramp; priority over start
cfg_target  input  WIDTH_W  final duty setting
cfg_step  input  WIDTH_W  increment/decrement per step; 0 treated as 1
cfg_dwell  input  DWELL_W  extra cycles held at each level (period = cfg_dwell+1)
cfg_clk  input  CLK_W  PWM clock-select applied for this ramp
busy  output  1  high in LOAD and RAMP
done  output  1  one-cycle pulse on normal completion
sel_width  output  WIDTH_W  to `pwm.sel_width`
sel_clk  output  CLK_W  to `pwm.sel_clk`
pwm_s_rst  output  1  to `pwm.s_rst`; resynchronises the PWM divider

Behaviour:
- One clock, `clk`. Reset `s_rst` is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE
  - sel_width=0, sel_clk=0
  - busy=0, done=0
  - pwm_s_rst=1, cleared on the first edge after `s_rst` drops
  - dwell counter=0
- `cfg_*` are latched into internal registers only on IDLE→LOAD. Later changes to `cfg_*` have no effect mid-ramp.
- States: IDLE, LOAD, RAMP, DONE.
- IDLE:
  - busy=0, done=0, pwm_s_rst=0.
  - On an edge with start=1 and abort=0: latch config, go to LOAD. sel_clk<=cfg_clk and pwm_s_rst<=1 at that same edge.
- LOAD (exactly 1 cycle):
  - busy=1, pwm_s_rst=1.
  - Next edge: pwm_s_rst<=0, cnt<=dwell, go to RAMP.
- RAMP:
  - busy=1.
  - If cnt≠0: cnt<=cnt-1.
  - If cnt==0 and sel_width==target: go to DONE.
  - If cnt==0 and sel_width≠target: sel_width<=next, cnt<=dwell.
  - So each level is held dwell+1 cycles, including the initial level.
- Step arithmetic, done in WIDTH_W+1 bits:
  - Up (target>sel_width): next = min(sel_width+step, target).
  - Down: next = max(sel_width−step, target).
  - No overshoot, no wrap-around.
- DONE (1 cycle): busy=0, done=1. Next edge → IDLE, done<=0. sel_width and sel_clk are retained.
- start while busy: ignored, not queued.
- abort=1 in LOAD or RAMP: next edge → IDLE, busy<=0, pwm_s_rst<=0, no done pulse. sel_width keeps its current value.
- abort in IDLE or DONE: no effect, DONE still completes normally.
- target equal to current sel_width: no width change, done after dwell+1 RAMP cycles.
- Reset mid-ramp: all outputs return to reset values on that edge.

Decomposition:
- Shared package `pwm_pkg`:
  - state enum {IDLE, LOAD, RAMP, DONE}
  - default width constants (WIDTH_W=4, CLK_W=4)
  - saturating step function `ramp_next(cur, tgt, step)`
- Sub-module: `pwm_dwell_timer`, a loadable down-counter with a zero flag. Everything else stays flat.

Test Plan:
1. Reset: hold s_rst 2 cycles → sel_width=0, sel_clk=0, busy=0, done=0, pwm_s_rst=1; pwm_s_rst=0 one edge after release.
2. Up ramp: from sel_width=0, target=4, step=1, dwell=2, clk=3, start at edge 0 → LOAD after edge 0 with sel_clk=3 and pwm_s_rst=1; sel_width becomes 1, 2, 3, 4 at edges 4, 7, 10, 13; done=1 after edge 16 for exactly one cycle; busy=0 after edge 16.
3. Down ramp with saturation: sel_width=12, target=3, step=5, dwell=0 → sequence 12→7→3, never below 3; one done pulse.
4. step=0 and target==current: step=0 ramps by 1; target equal to current sel_width → no width change, done after dwell+1 RAMP cycles.
5. Abort: abort asserted during RAMP at sel_width=2 of a 0→8 ramp → IDLE next edge, sel_width stays 2, busy=0, no done; a start issued the same cycle as abort is ignored.
6. Busy start and mid-ramp reset: start pulses during RAMP have no effect on the sequence; s_rst during RAMP → all outputs reach reset values on that edge.
